// File: rtl/vram_rect_fill.sv
// vram_rect_fill: raster-order rectangle fill engine driving VRAM port B, one byte per cycle.
// Define VRAM_FILL_CLIP_EN to clip rectangles to the FB_W x FB_H window.
module vram_rect_fill #(
  parameter int ADDR_W = 18,
  parameter int FB_W = 320,
  parameter int FB_H = 240
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [ADDR_W-1:0] BASE_ADDR,
  input  logic              CMD_VALID,
  output logic              CMD_READY,
  input  logic [9:0]        CMD_X,
  input  logic [9:0]        CMD_Y,
  input  logic [9:0]        CMD_W,
  input  logic [9:0]        CMD_H,
  input  logic [7:0]        CMD_COLOR,
  output logic [ADDR_W-1:0] ADDR_B,
  output logic [7:0]        DATA_B,
  output logic              WE_B,
  output logic              BUSY,
  output logic              DONE
);
  typedef enum logic [1:0] {IDLE, SETUP, FILL} state_t;
  state_t state, state_n;
  logic [9:0] x0, y0, w, h, col, row, x0_n, y0_n, w_n, h_n, col_n, row_n;
  logic [7:0] color, color_n, data_n;
  logic [ADDR_W-1:0] base, base_n, row_base, row_base_n, rb, addr_n;
  logic [10:0] w_eff, h_eff;
  logic we_n, busy_n, done_n, ready_n, last_col, emit;
`ifdef VRAM_FILL_CLIP_EN
  assign w_eff = ({1'b0, x0} >= 11'(FB_W)) ? 11'd0 :
                 ({1'b0, w} < 11'(FB_W) - {1'b0, x0}) ? {1'b0, w} : 11'(FB_W) - {1'b0, x0};
  assign h_eff = ({1'b0, y0} >= 11'(FB_H)) ? 11'd0 :
                 ({1'b0, h} < 11'(FB_H) - {1'b0, y0}) ? {1'b0, h} : 11'(FB_H) - {1'b0, y0};
`else
  assign w_eff = {1'b0, w};
  assign h_eff = {1'b0, h};
`endif
  // SETUP seeds the running row base; FILL then advances it by one stride per row
  assign rb = (state == SETUP) ? base + ADDR_W'(y0) * ADDR_W'(FB_W) : row_base;
  assign last_col = ({1'b0, col} + 11'd1) == w_eff;
  assign emit = (state == SETUP && w_eff != 11'd0 && h_eff != 11'd0) ||
                (state == FILL && {1'b0, row} != h_eff);
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      state <= IDLE;
      x0 <= '0;
      y0 <= '0;
      w <= '0;
      h <= '0;
      col <= '0;
      row <= '0;
      color <= '0;
      base <= '0;
      row_base <= '0;
      ADDR_B <= '0;
      DATA_B <= '0;
      WE_B <= 1'b0;
      BUSY <= 1'b0;
      DONE <= 1'b0;
      CMD_READY <= 1'b1;
    end else begin
      state <= state_n;
      x0 <= x0_n;
      y0 <= y0_n;
      w <= w_n;
      h <= h_n;
      col <= col_n;
      row <= row_n;
      color <= color_n;
      base <= base_n;
      row_base <= row_base_n;
      ADDR_B <= addr_n;
      DATA_B <= data_n;
      WE_B <= we_n;
      BUSY <= busy_n;
      DONE <= done_n;
      CMD_READY <= ready_n;
    end
  always_comb begin
    state_n = state;
    x0_n = x0;
    y0_n = y0;
    w_n = w;
    h_n = h;
    col_n = col;
    row_n = row;
    color_n = color;
    base_n = base;
    row_base_n = row_base;
    addr_n = ADDR_B;
    data_n = DATA_B;
    we_n = 1'b0;
    done_n = 1'b0;
    busy_n = BUSY;
    ready_n = CMD_READY;
    if (state == IDLE && CMD_VALID) begin
      x0_n = CMD_X;
      y0_n = CMD_Y;
      w_n = CMD_W;
      h_n = CMD_H;
      color_n = CMD_COLOR;
      base_n = BASE_ADDR;
      col_n = '0;
      row_n = '0;
      state_n = SETUP;
      busy_n = 1'b1;
      ready_n = 1'b0;
    end
    if (emit) begin
      we_n = 1'b1;
      addr_n = rb + ADDR_W'(x0) + ADDR_W'(col);
      data_n = color;
      col_n = last_col ? 10'd0 : col + 10'd1;
      row_n = row + {9'd0, last_col};
      row_base_n = last_col ? rb + ADDR_W'(FB_W) : rb;
      state_n = FILL;
    end else if (state != IDLE) begin
      state_n = IDLE;
      done_n = 1'b1;
      busy_n = 1'b0;
      ready_n = 1'b1;
    end
  end
endmodule

// File: tb/tb_vram_rect_fill.sv
// tb_vram_rect_fill: scoreboard bench for vram_rect_fill; expected writes queued at command time.
module tb_vram_rect_fill;
  localparam int FB_W = 320;
  localparam int FB_H = 240;
  logic CLK = 0, RST_N = 0, CMD_VALID = 0;
  logic [17:0] BASE_ADDR = '0;
  logic [9:0] CMD_X = '0, CMD_Y = '0, CMD_W = '0, CMD_H = '0;
  logic [7:0] CMD_COLOR = '0;
  logic CMD_READY, WE_B, BUSY, DONE;
  logic [17:0] ADDR_B;
  logic [7:0] DATA_B;
  int errors = 0, checks = 0, cyc = 0;
  int nwrites = 0, done_count = 0, first_we_cyc = -1, last_we_cyc = -1, done_cyc = -1;
  logic [25:0] q[$];

  vram_rect_fill dut (
    .CLK(CLK), .RST_N(RST_N), .BASE_ADDR(BASE_ADDR), .CMD_VALID(CMD_VALID),
    .CMD_READY(CMD_READY), .CMD_X(CMD_X), .CMD_Y(CMD_Y), .CMD_W(CMD_W), .CMD_H(CMD_H),
    .CMD_COLOR(CMD_COLOR), .ADDR_B(ADDR_B), .DATA_B(DATA_B), .WE_B(WE_B), .BUSY(BUSY),
    .DONE(DONE)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic monitor();
    logic prev_we;
    logic [25:0] exp_w;
    prev_we = 1'b0;
    forever begin
      @(negedge CLK);
      if (!RST_N) prev_we = 1'b0;
      else begin
        if (WE_B) begin
          nwrites++;
          last_we_cyc = cyc;
          if (!prev_we) first_we_cyc = cyc;
          checks++;
          if (q.size() == 0) begin
            errors++;
            $display("FAIL write_unexpected: addr=%0d data=%h, required no write", ADDR_B, DATA_B);
          end else begin
            exp_w = q.pop_front();
            if ({ADDR_B, DATA_B} !== exp_w) begin
              errors++;
              $display("FAIL write_data: addr=%0d data=%h, required addr=%0d data=%h",
                       ADDR_B, DATA_B, exp_w[25:8], exp_w[7:0]);
            end
          end
        end
        if (DONE) begin
          done_count++;
          done_cyc = cyc;
        end
        prev_we = WE_B;
      end
    end
  endtask

  task automatic expect_rect(input logic [17:0] base, input int x, y, w, h, input logic [7:0] c,
                             output int n);
    int we, he;
    we = w;
    he = h;
`ifdef VRAM_FILL_CLIP_EN
    we = (x >= FB_W) ? 0 : (w < FB_W - x) ? w : FB_W - x;
    he = (y >= FB_H) ? 0 : (h < FB_H - y) ? h : FB_H - y;
`endif
    n = we * he;
    for (int r = 0; r < he; r++)
      for (int cc = 0; cc < we; cc++)
        q.push_back({18'(int'(base) + (y + r) * FB_W + x + cc), c});
  endtask

  task automatic send_cmd(input logic [17:0] base, input int x, y, w, h, input logic [7:0] c,
                          output int acc, output bit ok, output bit done_at_acc);
    @(negedge CLK);
    BASE_ADDR = base;
    CMD_X = 10'(x);
    CMD_Y = 10'(y);
    CMD_W = 10'(w);
    CMD_H = 10'(h);
    CMD_COLOR = c;
    CMD_VALID = 1'b1;
    ok = 0;
    done_at_acc = 0;
    for (int i = 0; i < 3000; i++) begin
      if (CMD_READY) begin
        ok = 1;
        done_at_acc = DONE;
        break;
      end
      @(negedge CLK);
    end
    if (ok) @(negedge CLK);
    CMD_VALID = 1'b0;
    acc = cyc;
    #1;
  endtask

  task automatic wait_done(input int start, output bit ok);
    ok = 0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge CLK);
      if (done_count > start) begin
        ok = 1;
        break;
      end
    end
    @(negedge CLK);
    #1;
  endtask

  task automatic run_rect(input string name, input logic [17:0] base, input int x, y, w, h,
                          input logic [7:0] c);
    int n, n0, d0, acc;
    bit ok, wd;
    expect_rect(base, x, y, w, h, c, n);
    n0 = nwrites;
    d0 = done_count;
    send_cmd(base, x, y, w, h, c, acc, ok, wd);
    wait_done(d0, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s_timeout: no DONE seen, required DONE", name);
    end
    checks++;
    if (nwrites - n0 !== n) begin
      errors++;
      $display("FAIL %s_count: got %0d writes, required %0d", name, nwrites - n0, n);
    end
    checks++;
    if (n > 0 && done_cyc !== last_we_cyc + 1) begin
      errors++;
      $display("FAIL %s_done_timing: DONE at %0d, required %0d", name, done_cyc, last_we_cyc + 1);
    end
    q.delete();
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      checks++;
      if ({CMD_READY, WE_B, BUSY, DONE} !== 4'b1000) begin
        errors++;
        $display("FAIL reset_idle: ready/we/busy/done=%b, required 1000",
                 {CMD_READY, WE_B, BUSY, DONE});
      end
    end
  endtask

  task automatic test_basic();
    int n, n0, d0, acc;
    bit ok, wd;
    expect_rect(18'd0, 2, 1, 3, 2, 8'hA5, n);
    n0 = nwrites;
    d0 = done_count;
    send_cmd(18'd0, 2, 1, 3, 2, 8'hA5, acc, ok, wd);
    checks++;
    if (!ok || BUSY !== 1'b1 || CMD_READY !== 1'b0) begin
      errors++;
      $display("FAIL basic_accept: accepted=%0d busy=%b ready=%b, required 1 1 0", ok, BUSY, CMD_READY);
    end
    wait_done(d0, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL basic_timeout: no DONE seen, required DONE");
    end
    checks++;
    if (nwrites - n0 !== 6) begin
      errors++;
      $display("FAIL basic_count: got %0d writes, required 6", nwrites - n0);
    end
    checks++;
    if (first_we_cyc !== acc + 1) begin
      errors++;
      $display("FAIL basic_first_write: at cycle %0d, required %0d", first_we_cyc, acc + 1);
    end
    checks++;
    if (done_cyc !== last_we_cyc + 1 || BUSY !== 1'b0) begin
      errors++;
      $display("FAIL basic_done: DONE at %0d busy=%b, required %0d busy=0", done_cyc, BUSY, last_we_cyc + 1);
    end
    checks++;
    if (q.size() !== 0) begin
      errors++;
      $display("FAIL basic_missing: %0d writes left, required 0", q.size());
    end
  endtask

  task automatic test_empty();
    int n0, d0, acc;
    bit ok, wd;
    n0 = nwrites;
    d0 = done_count;
    send_cmd(18'd0, 4, 4, 0, 5, 8'h11, acc, ok, wd);
    wait_done(d0, ok);
    checks++;
    if (!ok || done_cyc !== acc + 1) begin
      errors++;
      $display("FAIL empty_done: DONE at %0d, required %0d", done_cyc, acc + 1);
    end
    checks++;
    if (nwrites !== n0) begin
      errors++;
      $display("FAIL empty_count: got %0d writes, required 0", nwrites - n0);
    end
  endtask

  task automatic test_clip();
    run_rect("clip_corner", 18'd0, 318, 239, 10, 10, 8'h5A);
    run_rect("wrap_top", 18'd262000, 300, 0, 40, 3, 8'hC3);
    run_rect("off_screen", 18'd0, 400, 10, 2, 2, 8'h77);
  endtask

  task automatic test_random();
    for (int i = 0; i < 4; i++)
      run_rect("random", 18'($urandom), $urandom_range(0, 330), $urandom_range(0, 250),
               $urandom_range(1, 12), $urandom_range(1, 4), 8'($urandom));
  endtask

  task automatic test_back_to_back();
    int na, nb, n0, d0, acc1, acc2;
    bit ok1, ok2, wd1, wd2;
    expect_rect(18'd0, 5, 5, 3, 2, 8'h11, na);
    expect_rect(18'd1000, 0, 0, 2, 2, 8'h22, nb);
    n0 = nwrites;
    d0 = done_count;
    send_cmd(18'd0, 5, 5, 3, 2, 8'h11, acc1, ok1, wd1);
    send_cmd(18'd1000, 0, 0, 2, 2, 8'h22, acc2, ok2, wd2);
    checks++;
    if (!ok2 || !wd2 || done_cyc !== acc2 - 1) begin
      errors++;
      $display("FAIL b2b_accept: accepted=%0d in_done=%0d done_cyc=%0d, required 1 1 %0d",
               ok2, wd2, done_cyc, acc2 - 1);
    end
    wait_done(d0 + 1, ok2);
    checks++;
    if (!ok2 || first_we_cyc !== acc2 + 1) begin
      errors++;
      $display("FAIL b2b_second_start: first write %0d, required %0d", first_we_cyc, acc2 + 1);
    end
    checks++;
    if (nwrites - n0 !== na + nb || q.size() !== 0) begin
      errors++;
      $display("FAIL b2b_count: got %0d writes, required %0d", nwrites - n0, na + nb);
    end
  endtask

  task automatic test_reset_mid();
    int n, n0, d0, acc;
    bit ok, wd;
    expect_rect(18'd0, 10, 10, 4, 4, 8'h3C, n);
    n0 = nwrites;
    d0 = done_count;
    send_cmd(18'd0, 10, 10, 4, 4, 8'h3C, acc, ok, wd);
    repeat (5) @(negedge CLK);
    #1;
    RST_N = 1'b0;
    #1;
    checks++;
    if ({WE_B, BUSY, DONE, CMD_READY} !== 4'b0001 || ADDR_B !== 18'd0 || DATA_B !== 8'd0) begin
      errors++;
      $display("FAIL rst_mid_async: we/busy/done/ready=%b addr=%0d data=%h, required 0001 0 00",
               {WE_B, BUSY, DONE, CMD_READY}, ADDR_B, DATA_B);
    end
    q.delete();
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    repeat (10) @(negedge CLK);
    #1;
    checks++;
    if (nwrites - n0 !== 5 || done_count !== d0) begin
      errors++;
      $display("FAIL rst_mid_writes: writes=%0d dones=%0d, required 5 0", nwrites - n0, done_count - d0);
    end
    checks++;
    if (CMD_READY !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_ready: ready=%b, required 1", CMD_READY);
    end
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_basic();
    test_empty();
    test_clip();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
